// File: rtl/u_enc_if.sv
// Streaming handshake bundle for the unary encoder: count/form in, unary word out.
interface u_enc_if #(
  parameter int unsigned W           = 16,
  parameter int unsigned P_ERR_CNT_W = 8
);
  localparam int unsigned CW = $clog2(W + 1);

  logic                   i_in_vld;
  logic [CW-1:0]          i_in_cnt;
  logic                   i_in_compliment;
  logic                   o_in_rdy;
  logic                   o_out_vld;
  logic [W-1:0]           o_out_x;
  logic                   o_out_is_compliment;
  logic                   o_out_err;
  logic                   i_out_rdy;
  logic [P_ERR_CNT_W-1:0] o_err_cnt;

  // Producer/consumer side driving the encoder.
  modport master (
    output i_in_vld, i_in_cnt, i_in_compliment, i_out_rdy,
    input  o_in_rdy, o_out_vld, o_out_x, o_out_is_compliment, o_out_err, o_err_cnt
  );

  // The encoder itself.
  modport slave (
    input  i_in_vld, i_in_cnt, i_in_compliment, i_out_rdy,
    output o_in_rdy, o_out_vld, o_out_x, o_out_is_compliment, o_out_err, o_err_cnt
  );
endinterface

// File: rtl/u_enc.sv
// Binary-to-unary (thermometer) encoder with a 2-entry output skid buffer
// and a saturating out-of-range counter.
module u_enc #(
  parameter int unsigned W                     = 16,
  parameter int unsigned P_ADMIT_COMPLIMENT_EN = 1,
  parameter int unsigned P_ERR_CNT_W           = 8
) (
  input  logic   clk,
  input  logic   rst,
  u_enc_if.slave bus
);
  localparam int unsigned   CW    = $clog2(W + 1);
  localparam logic [CW-1:0] W_CNT = CW'(W);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           head_x_q, head_x_d, tail_x_q, tail_x_d;
  logic                   head_cmp_q, head_cmp_d, tail_cmp_q, tail_cmp_d;
  logic                   head_err_q, head_err_d, tail_err_q, tail_err_d;
  logic [P_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                   in_rdy_q, in_rdy_d;
  logic                   out_vld_q, out_vld_d;

  logic                   enc_err_c;
  logic [CW-1:0]          enc_k_c;
  logic [W-1:0]           code_c;
  logic [W-1:0]           enc_x_c;
  logic                   enc_cmp_c;
  logic                   push_c;
  logic                   pop_c;

  // Combinational encode of the incoming word (count clamped to W).
  always_comb begin
    code_c    = '0;
    enc_err_c = (bus.i_in_cnt > W_CNT);
    enc_k_c   = enc_err_c ? W_CNT : bus.i_in_cnt;
    enc_cmp_c = bus.i_in_compliment & (P_ADMIT_COMPLIMENT_EN != 0);
    for (int i = 0; i < W; i++) begin
      code_c[i] = (CW'(i) < enc_k_c);
    end
    enc_x_c   = enc_cmp_c ? ~code_c : code_c;
  end

  assign push_c = bus.i_in_vld & in_rdy_q;
  assign pop_c  = out_vld_q & bus.i_out_rdy;

  // Next-state for the skid buffer, handshake flags and error counter.
  always_comb begin
    state_d    = state_q;
    head_x_d   = head_x_q;
    head_cmp_d = head_cmp_q;
    head_err_d = head_err_q;
    tail_x_d   = tail_x_q;
    tail_cmp_d = tail_cmp_q;
    tail_err_d = tail_err_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      S_EMPTY: begin
        if (push_c) begin
          head_x_d   = enc_x_c;
          head_cmp_d = enc_cmp_c;
          head_err_d = enc_err_c;
          state_d    = S_ONE;
        end
      end
      S_ONE: begin
        if (push_c && pop_c) begin
          head_x_d   = enc_x_c;
          head_cmp_d = enc_cmp_c;
          head_err_d = enc_err_c;
        end else if (push_c) begin
          tail_x_d   = enc_x_c;
          tail_cmp_d = enc_cmp_c;
          tail_err_d = enc_err_c;
          state_d    = S_FULL;
        end else if (pop_c) begin
          state_d    = S_EMPTY;
        end
      end
      S_FULL: begin
        // Input is stalled here, so only a pop can occur.
        if (pop_c) begin
          head_x_d   = tail_x_q;
          head_cmp_d = tail_cmp_q;
          head_err_d = tail_err_q;
          state_d    = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (push_c && enc_err_c && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + P_ERR_CNT_W'(1);
    end

    in_rdy_d  = (state_d != S_FULL);
    out_vld_d = (state_d != S_EMPTY);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      head_x_q   <= '0;
      head_cmp_q <= 1'b0;
      head_err_q <= 1'b0;
      tail_x_q   <= '0;
      tail_cmp_q <= 1'b0;
      tail_err_q <= 1'b0;
      err_cnt_q  <= '0;
      in_rdy_q   <= 1'b1;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_x_q   <= head_x_d;
      head_cmp_q <= head_cmp_d;
      head_err_q <= head_err_d;
      tail_x_q   <= tail_x_d;
      tail_cmp_q <= tail_cmp_d;
      tail_err_q <= tail_err_d;
      err_cnt_q  <= err_cnt_d;
      in_rdy_q   <= in_rdy_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign bus.o_in_rdy            = in_rdy_q;
  assign bus.o_out_vld           = out_vld_q;
  assign bus.o_out_x             = head_x_q;
  assign bus.o_out_is_compliment = head_cmp_q;
  assign bus.o_out_err           = head_err_q;
  assign bus.o_err_cnt           = err_cnt_q;
endmodule
